uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg : UART state encodings and 16x tick constants, shared by RX and TX.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [3:0] TICK_MID  = 4'd7;
  localparam logic [3:0] TICK_FULL = 4'd15;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer for a single asynchronous input.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx : 16x-oversampled UART receiver with ready/valid output and sticky
//           frame/overrun flags. Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            frame_err,
  output logic            overrun,
  input  logic            err_clr
);

  // The stop bit can span up to 32 ticks, so the stop phase counts on the
  // concatenation {n_cnt, s_cnt}; n_cnt is otherwise idle during STOP.
  localparam logic [6:0] STOP_LAST = 7'(SB_TICK - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DBIT - 1);

  logic            rx_s;
  uart_state_t     state;
  logic [3:0]      s_cnt;
  logic [2:0]      n_cnt;
  logic [DBIT-1:0] shreg;
  logic            stop_done;
  logic            frame_ok;
  logic            frame_bad;
  logic            take;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign stop_done = (state == STOP) && s_tick && ({n_cnt, s_cnt} == STOP_LAST);
  assign frame_ok  = stop_done && rx_s;
  assign frame_bad = stop_done && !rx_s;
  assign take      = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      s_cnt     <= 4'd0;
      n_cnt     <= 3'd0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= 4'd0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_cnt == TICK_MID) begin
              s_cnt <= 4'd0;
              n_cnt <= 3'd0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_cnt == TICK_FULL) begin
              s_cnt <= 4'd0;
              shreg <= {rx_s, shreg[DBIT-1:1]};
              if (n_cnt == LAST_BIT) begin
                n_cnt <= 3'd0;
                state <= STOP;
              end else begin
                n_cnt <= n_cnt + 3'd1;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (stop_done) begin
              s_cnt <= 4'd0;
              n_cnt <= 3'd0;
              state <= IDLE;
            end else begin
              {n_cnt, s_cnt} <= {n_cnt, s_cnt} + 7'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A new byte may load in the same cycle the old one is consumed.
      if (frame_ok && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (take) begin
        rx_valid <= 1'b0;
      end

      if (frame_ok && rx_valid && !rx_ready) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end

      if (frame_bad) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx : directed self-checking bench for uart_rx (8N1, 16x ticks).
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  // Tick period shortened from 54 clocks so the run stays short; the
  // receiver only ever sees s_tick, so bit timing is otherwise unchanged.
  localparam int TICK_DIV   = 10;
  localparam int BIT_CLKS   = 16 * TICK_DIV;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       s_tick    = 1'b0;
  logic       rx        = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready  = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       err_clr   = 1'b0;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         div_cnt = 0;
  int         tick_total = 0;
  logic       tick_seen = 1'b0;
  bit         cap_en = 1'b0;
  logic [7:0] cap_q[$];

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_tick    (s_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (div_cnt == TICK_DIV - 1) begin
      div_cnt = 0;
      s_tick  = 1'b1;
    end else begin
      div_cnt = div_cnt + 1;
      s_tick  = 1'b0;
    end
  end

  always @(posedge clk) begin
    tick_seen <= s_tick;
    if (s_tick) tick_total <= tick_total + 1;
  end

  always @(negedge clk) begin
    if (cap_en && rx_valid && rx_ready) cap_q.push_back(rx_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] data, input int bit_clks, input bit stop_low);
    @(negedge clk);
    rx = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (bit_clks) @(negedge clk);
    end
    if (stop_low) begin
      // Low only through the sample point so the tail is a short glitch.
      rx = 1'b0;
      repeat (bit_clks * 10 / 16) @(negedge clk);
      rx = 1'b1;
      repeat (bit_clks - bit_clks * 10 / 16) @(negedge clk);
    end else begin
      rx = 1'b1;
      repeat (bit_clks) @(negedge clk);
    end
  endtask

  // Raise rx_ready for exactly the clock holding the final stop-bit tick:
  // START is entered 3 edges after rx falls, then 8 + 8*16 + 16 = 152 ticks.
  task automatic arm_ready_at_completion();
    int base;
    wait (rx == 1'b0);
    repeat (3) @(posedge clk);
    #1 base = tick_total;
    for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
      @(posedge clk);
      #1;
      if (tick_total == base + 151) break;
    end
    repeat (TICK_DIV - 1) @(posedge clk);
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want %h", rx_data, 8'h00); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    bit got = 1'b0;
    logic lat = 1'b0;
    rx_ready = 1'b0;
    fork
      send_byte(8'hA5, BIT_CLKS, 1'b0);
      begin
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
          @(negedge clk);
          if (rx_valid) begin got = 1'b1; lat = tick_seen; break; end
        end
      end
    join
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL single_timeout: rx_valid seen %b want 1", got); end
    n_cmp++; if (lat !== 1'b1) begin n_bad++; $display("FAIL single_latency: tick on rising edge %b want 1", lat); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want %h", rx_data, 8'hA5); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", rx_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL single_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL single_overrun: got %b want 0", overrun); end
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL single_consume: valid %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL single_hold: got %h want %h", rx_data, 8'hA5); end
  endtask

  task automatic test_glitch();
    @(negedge clk) rx = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (20 * TICK_DIV) @(negedge clk);
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL glitch_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL glitch_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_frame_err();
    rx_ready = 1'b0;
    send_byte(8'h3C, BIT_CLKS, 1'b1);
    repeat (20 * TICK_DIV) @(negedge clk);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_set: got %b want 1", frame_err); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL ferr_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL ferr_data_kept: got %h want %h", rx_data, 8'hA5); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ferr_overrun: got %b want 0", overrun); end
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
  endtask

  task automatic test_overrun();
    rx_ready = 1'b0;
    send_byte(8'h11, BIT_CLKS, 1'b0);
    n_cmp++; if (rx_data !== 8'h11) begin n_bad++; $display("FAIL ovr_first_data: got %h want %h", rx_data, 8'h11); end
    send_byte(8'h22, BIT_CLKS, 1'b0);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
    n_cmp++; if (rx_data !== 8'h11) begin n_bad++; $display("FAIL ovr_data_kept: got %h want %h", rx_data, 8'h11); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    fork
      send_byte(8'h22, BIT_CLKS, 1'b0);
      arm_ready_at_completion();
    join
    n_cmp++; if (rx_data !== 8'h22) begin n_bad++; $display("FAIL ovr_same_cycle_data: got %h want %h", rx_data, 8'h22); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_same_cycle_valid: got %b want 1", rx_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_same_cycle_flag: got %b want 0", overrun); end
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    fork
      send_byte(8'hFF, BIT_CLKS, 1'b0);
      begin
        repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data_cleared: got %h want %h", rx_data, 8'h00); end
        reset = 1'b1;
      end
    join
    repeat (20 * TICK_DIV) @(negedge clk);
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_output: valid %b want 0", rx_valid); end
    send_byte(8'h5A, BIT_CLKS, 1'b0);
    n_cmp++; if (rx_data !== 8'h5A) begin n_bad++; $display("FAIL rstmid_next_data: got %h want %h", rx_data, 8'h5A); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_next_valid: got %b want 1", rx_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_frame_err: got %b want 0", frame_err); end
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    int         bclk  [3];
    logic [7:0] got;
    exp_b = '{8'h00, 8'hFF, 8'h55};
    bclk  = '{BIT_CLKS * 98 / 100, BIT_CLKS * 102 / 100, BIT_CLKS * 98 / 100};
    cap_q.delete();
    rx_ready = 1'b1;
    cap_en   = 1'b1;
    for (int k = 0; k < 3; k++) send_byte(exp_b[k], bclk[k], 1'b0);
    repeat (20 * TICK_DIV) @(negedge clk);
    cap_en   = 1'b0;
    rx_ready = 1'b0;
    n_cmp++; if (cap_q.size() !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", cap_q.size()); end
    for (int k = 0; k < 3; k++) begin
      got = (k < cap_q.size()) ? cap_q[k] : 8'hxx;
      n_cmp++; if (got !== exp_b[k]) begin n_bad++; $display("FAIL b2b_byte%0d: got %h want %h", k, got, exp_b[k]); end
    end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL b2b_frame_err: got %b want 0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
